// File: rtl/psum_wb_pkg.sv
// Shared types and sizing for the partial-sum writeback drain stage.
package psum_wb_pkg;

  localparam int unsigned COL     = 8;
  localparam int unsigned PSUM_BW = 16;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned VEC_W   = COL * PSUM_BW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  typedef logic signed [PSUM_BW-1:0] lane_t;

  // Run controls captured on start and held for the whole run.
  typedef struct packed {
    logic              acc_mode;
    logic              relu_en;
    logic [ADDR_W-1:0] num_vec;
  } run_cfg_t;

endpackage

// File: rtl/psum_lane_alu.sv
// One lane of the writeback datapath: optional wrap-around accumulate, then optional ReLU.
module psum_lane_alu
  import psum_wb_pkg::*;
(
  input  lane_t a_i,
  input  lane_t b_i,
  input  logic  acc_en_i,
  input  logic  relu_en_i,
  output lane_t result_o
);

  lane_t sum_c;

  // Sum truncates to the lane width; negative results are zeroed when ReLU is on.
  always_comb begin
    sum_c    = acc_en_i ? lane_t'(a_i + b_i) : a_i;
    result_o = (relu_en_i && sum_c[PSUM_BW-1]) ? lane_t'(0) : sum_c;
  end

endmodule

// File: rtl/psum_writeback.sv
// Drains OFIFO vectors into PMEM at consecutive addresses, with optional
// read-modify-write accumulation and ReLU, then pulses done.
module psum_writeback
  import psum_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_vec,
  input  logic              acc_mode,
  input  logic              relu_en,
  input  logic              ofifo_valid,
  input  logic [VEC_W-1:0]  ofifo_out,
  output logic              ofifo_rd,
  output logic              pmem_cen,
  output logic              pmem_wen,
  output logic [ADDR_W-1:0] pmem_a,
  output logic [VEC_W-1:0]  pmem_d,
  input  logic [VEC_W-1:0]  pmem_q,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  run_cfg_t          cfg_q, cfg_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [VEC_W-1:0]  dreg_q, dreg_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ofifo_rd_c;
  logic [VEC_W-1:0]  alu_res_c;
  lane_t             lane_res [COL];

  // Per-lane datapath; pmem_q carries the read issued in RD, so it is valid in WR.
  for (genvar g = 0; g < COL; g++) begin : g_lane
    psum_lane_alu u_alu (
      .a_i       (lane_t'(vec_q[g*PSUM_BW +: PSUM_BW])),
      .b_i       (lane_t'(pmem_q[g*PSUM_BW +: PSUM_BW])),
      .acc_en_i  (cfg_q.acc_mode),
      .relu_en_i (cfg_q.relu_en),
      .result_o  (lane_res[g])
    );
    assign alu_res_c[g*PSUM_BW +: PSUM_BW] = lane_res[g];
  end

  // Next-state, counters and output decode; strobes follow the next state so they align with it.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    vec_d      = vec_q;
    dreg_d     = dreg_q;
    a_d        = a_q;
    ofifo_rd_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d.acc_mode = acc_mode;
          cfg_d.relu_en  = relu_en;
          cfg_d.num_vec  = num_vec;
          cnt_d          = '0;
          addr_d         = base_addr;
          state_d        = (num_vec == '0) ? ST_DONE : ST_POP;
        end
      end
      ST_POP: begin
        if (ofifo_valid) begin
          ofifo_rd_c = 1'b1;
          vec_d      = ofifo_out;
          state_d    = cfg_q.acc_mode ? ST_RD : ST_WR;
        end
      end
      ST_RD: begin
        state_d = ST_WR;
      end
      ST_WR: begin
        dreg_d  = alu_res_c;
        cnt_d   = cnt_q + ADDR_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = ((cnt_q + ADDR_W'(1)) == cfg_q.num_vec) ? ST_DONE : ST_POP;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cen_d  = !((state_d == ST_RD) || (state_d == ST_WR));
    wen_d  = !(state_d == ST_WR);
    if ((state_d == ST_RD) || (state_d == ST_WR)) begin
      a_d = addr_q;
    end
    busy_d = (state_d == ST_POP) || (state_d == ST_RD) || (state_d == ST_WR);
    done_d = (state_d == ST_DONE);
  end

  // State, run context and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      vec_q   <= '0;
      dreg_q  <= '0;
      a_q     <= '0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      vec_q   <= vec_d;
      dreg_q  <= dreg_d;
      a_q     <= a_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ofifo_rd = ofifo_rd_c;
  assign pmem_cen = cen_q;
  assign pmem_wen = wen_q;
  assign pmem_a   = a_q;
  // Write data merges the read returning in WR, so it is steered live in WR and held afterwards.
  assign pmem_d   = (state_q == ST_WR) ? alu_res_c : dreg_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback with a behavioural OFIFO, PMEM and result model.
module tb_psum_writeback;
  import psum_wb_pkg::*;

  localparam int DW   = int'(VEC_W);
  localparam int LMAX = (1 << (PSUM_BW - 1)) - 1;
  localparam int LMIN = -(1 << (PSUM_BW - 1));
  localparam int LSPAN = 1 << PSUM_BW;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_vec;
  logic              acc_mode;
  logic              relu_en;
  logic              ofifo_valid;
  logic [DW-1:0]     ofifo_out;
  logic              ofifo_rd;
  logic              pmem_cen;
  logic              pmem_wen;
  logic [ADDR_W-1:0] pmem_a;
  logic [DW-1:0]     pmem_d;
  logic [DW-1:0]     pmem_q;
  logic              busy;
  logic              done;

  int n_chk = 0;
  int n_fail = 0;

  psum_writeback dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_vec(num_vec), .acc_mode(acc_mode), .relu_en(relu_en),
    .ofifo_valid(ofifo_valid), .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd),
    .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_a(pmem_a), .pmem_d(pmem_d),
    .pmem_q(pmem_q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // PMEM model: one-cycle read latency, plus a bench-side preload port.
  bit [DW-1:0]       mem [2048];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_a = '0;
  logic [DW-1:0]     pl_d = '0;
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!pmem_cen) begin
      if (!pmem_wen) mem[pmem_a] <= pmem_d;
      else pmem_q <= mem[pmem_a];
    end
  end

  // OFIFO model: array with pointers; a stall window can be opened after a chosen pop.
  bit [DW-1:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int npop = 0;
  int stall_left = 0;
  int stall_at = -1;
  int stall_len = 0;
  assign ofifo_valid = (rd_ptr != wr_ptr) && (stall_left == 0);
  assign ofifo_out   = fifo_mem[rd_ptr[5:0]];
  always @(posedge clk) begin
    if (ofifo_rd) begin
      rd_ptr <= rd_ptr + 1;
      npop   <= npop + 1;
    end
    if (ofifo_rd && stall_len > 0 && (npop + 1) == stall_at) stall_left <= stall_len;
    else if (stall_left > 0) stall_left <= stall_left - 1;
  end

  // Expected PMEM writes in order.
  logic [ADDR_W-1:0] exp_a [64];
  logic [DW-1:0]     exp_d [64];
  int exp_wr = 0;
  int exp_rd = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fill(input logic [PSUM_BW-1:0] x);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(COL); i++) r[i*PSUM_BW +: PSUM_BW] = x;
    return r;
  endfunction

  function automatic logic [DW-1:0] ramp(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(COL); i++) r[i*PSUM_BW +: PSUM_BW] = PSUM_BW'((i + 1) * v);
    return r;
  endfunction

  // Result rule in integer arithmetic: signed add, wrap into lane range, clamp negatives.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] v, input logic [DW-1:0] old,
                                          input logic acc, input logic relu);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(COL); i++) begin
      int s;
      s = int'($signed(v[i*PSUM_BW +: PSUM_BW]));
      if (acc) s = s + int'($signed(old[i*PSUM_BW +: PSUM_BW]));
      if (s > LMAX) s = s - LSPAN;
      else if (s < LMIN) s = s + LSPAN;
      if (relu && s < 0) s = 0;
      r[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(s);
    end
    return r;
  endfunction

  // Per-cycle compare against the model: writes, pop legality, stall quietness.
  always @(negedge clk) begin
    if (ofifo_rd) chk("pop_without_valid", DW'(ofifo_valid), DW'(1));
    if (stall_left > 0 && stall_left < stall_len) begin
      chk("stall_no_pop", DW'(ofifo_rd), DW'(0));
      chk("stall_no_pmem", DW'(pmem_cen), DW'(1));
    end
    if (!pmem_cen && !pmem_wen) begin
      if (exp_rd < exp_wr) begin
        chk("wr_addr", DW'(pmem_a), DW'(exp_a[exp_rd[5:0]]));
        chk("wr_data", pmem_d, exp_d[exp_rd[5:0]]);
        exp_rd <= exp_rd + 1;
      end else begin
        chk("spurious_write_wen", DW'(pmem_wen), DW'(1));
      end
    end
  end

  logic [DW-1:0] vin [16];

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push_vec(input logic [DW-1:0] v);
    fifo_mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d);
    exp_a[exp_wr[5:0]] = a;
    exp_d[exp_wr[5:0]] = d;
    exp_wr++;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ofifo_rd", DW'(ofifo_rd), DW'(0));
    chk("rst_pmem_cen", DW'(pmem_cen), DW'(1));
    chk("rst_pmem_wen", DW'(pmem_wen), DW'(1));
    chk("rst_pmem_a",   DW'(pmem_a),   DW'(0));
    chk("rst_pmem_d",   pmem_d,        DW'(0));
    chk("rst_busy",     DW'(busy),     DW'(0));
    chk("rst_done",     DW'(done),     DW'(0));
  endtask

  // One run: vectors from vin[0..n-1]; latency counted with the start cycle as cycle 1.
  task automatic run(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] n,
                     input logic acc, input logic relu, input int stall,
                     input int lat_exp, input logic dbl);
    int p0;
    int lat;
    logic [ADDR_W-1:0] a;
    p0 = npop;
    for (int i = 0; i < int'(n); i++) begin
      a = base + ADDR_W'(i);
      push_vec(vin[i]);
      push_exp(a, model(vin[i], mem[a], acc, relu));
    end
    stall_at  = p0 + 2;
    stall_len = stall;
    @(posedge clk); #1;
    base_addr = base; num_vec = n; acc_mode = acc; relu_en = relu; start = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 2) chk("busy_in_run", DW'(busy), DW'(n != '0));
      if (done) break;
      if (lat > 300) begin
        chk("done_timeout", DW'(done), DW'(1));
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (dbl && lat == 2) begin
        start = 1'b1; base_addr = 11'h060; num_vec = 11'd1; acc_mode = 1'b1; relu_en = 1'b1;
      end
    end
    start = 1'b0;
    chk("latency", DW'(lat), DW'(lat_exp));
    @(negedge clk);
    chk("done_one_cycle", DW'(done), DW'(0));
    chk("busy_after_done", DW'(busy), DW'(0));
    chk("pop_count", DW'(npop - p0), DW'(n));
    chk("writes_complete", DW'(exp_rd), DW'(exp_wr));
    stall_len = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; acc_mode = 1'b0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain copy, four vectors from 0x010.
    for (int v = 1; v <= 4; v++) vin[v-1] = ramp(v);
    run(11'h010, 11'd4, 1'b0, 1'b0, 0, 10, 1'b0);
    for (int v = 1; v <= 4; v++) chk("copy_literal", mem[11'h010 + ADDR_W'(v - 1)], ramp(v));

    // Accumulate and accumulate+ReLU.
    preload(11'h020, fill(16'd100));
    preload(11'h021, fill(16'd100));
    vin[0] = fill(PSUM_BW'(-30));
    run(11'h020, 11'd1, 1'b1, 1'b0, 0, 5, 1'b0);
    chk("acc_literal_70", mem[11'h020], fill(16'd70));
    vin[0] = fill(PSUM_BW'(-130));
    run(11'h021, 11'd1, 1'b1, 1'b1, 0, 5, 1'b0);
    chk("acc_relu_literal_0", mem[11'h021], fill(16'd0));

    // Lane wrap-around, with and without ReLU.
    preload(11'h030, fill(16'h7FFF));
    preload(11'h031, fill(16'h7FFF));
    vin[0] = fill(16'h0001);
    run(11'h030, 11'd1, 1'b1, 1'b0, 0, 5, 1'b0);
    chk("wrap_literal", mem[11'h030], fill(16'h8000));
    run(11'h031, 11'd1, 1'b1, 1'b1, 0, 5, 1'b0);
    chk("wrap_relu_literal", mem[11'h031], fill(16'h0000));

    // OFIFO empty for five cycles after the second pop; ReLU on mixed-sign data.
    vin[0] = fill(PSUM_BW'(-5));
    vin[1] = ramp(3);
    vin[2] = fill(16'h8000);
    vin[3] = fill(16'h7FFF);
    run(11'h040, 11'd4, 1'b0, 1'b1, 5, 14, 1'b0);
    chk("stall_relu_literal", mem[11'h040], fill(16'd0));
    chk("stall_pass_literal", mem[11'h043], fill(16'h7FFF));

    // Start during busy is ignored; then an empty run.
    vin[0] = ramp(7);
    vin[1] = ramp(9);
    run(11'h050, 11'd2, 1'b0, 1'b0, 0, 6, 1'b1);
    chk("ignored_start_no_write", mem[11'h060], DW'(0));
    run(11'h058, 11'd0, 1'b0, 1'b0, 0, 2, 1'b0);

    // Reset while reading vector 2 of 4; only vector 1 may land.
    vin[0] = ramp(11);
    vin[1] = ramp(13);
    push_vec(vin[0]);
    push_vec(vin[1]);
    push_exp(11'h070, model(vin[0], mem[11'h070], 1'b1, 1'b0));
    @(posedge clk); #1;
    base_addr = 11'h070; num_vec = 11'd4; acc_mode = 1'b1; relu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("in_rd_cen", DW'(pmem_cen), DW'(0));
    chk("in_rd_wen", DW'(pmem_wen), DW'(1));
    chk("in_rd_addr", DW'(pmem_a), DW'(11'h071));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_idle_busy", DW'(busy), DW'(0));
      chk("post_reset_idle_done", DW'(done), DW'(0));
    end
    chk("abandoned_writes", DW'(exp_rd), DW'(exp_wr));

    // Address wrap across the top of PMEM.
    vin[0] = ramp(21);
    vin[1] = ramp(22);
    vin[2] = ramp(23);
    run(11'h7FE, 11'd3, 1'b0, 1'b0, 0, 8, 1'b0);
    chk("addr_wrap_7fe", mem[11'h7FE], ramp(21));
    chk("addr_wrap_7ff", mem[11'h7FF], ramp(22));
    chk("addr_wrap_000", mem[11'h000], ramp(23));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
